// File: rtl/keycode_ball_ctrl.sv
// Keyboard-driven ball controller: keycode edge detect, velocity/direction register,
// and per-frame position update with wall bounce for the VGA colour mapper.
//
//   state  | meaning
//   S_IDLE | ball parked (after reset or SPACE), frame ticks ignored
//   S_RUN  | ball moves by (vx, vy) on each frame_tick, bouncing off the limits
module keycode_ball_ctrl #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int STEP     = 1,
  parameter int SIZE     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] ball_size,
  output logic [1:0] dir,
  output logic       moving,
  output logic       key_event
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic signed [10:0] X_LO = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - SIZE);

  localparam logic [9:0]        X_C    = 10'(X_CENTER);
  localparam logic [9:0]        Y_C    = 10'(Y_CENTER);
  localparam logic [9:0]        STEP_U = 10'(STEP);
  localparam logic signed [4:0] V_POS  = 5'(STEP);
  localparam logic signed [4:0] V_NEG  = 5'(-STEP);
  localparam logic signed [4:0] V_ZERO = 5'sd0;

  state_t            r_state;
  logic [7:0]        r_key_prev;
  logic [9:0]        r_ball_x;
  logic [9:0]        r_ball_y;
  logic signed [4:0] r_vx;
  logic signed [4:0] r_vy;
  logic [1:0]        r_dir;
  logic              r_key_event;

  state_t            w_state_nxt;
  logic [9:0]        w_ball_x_nxt;
  logic [9:0]        w_ball_y_nxt;
  logic signed [4:0] w_vx_nxt;
  logic signed [4:0] w_vy_nxt;
  logic [1:0]        w_dir_nxt;
  logic              w_key_event_nxt;

  logic              w_new_key;
  logic              w_is_dir_key;
  logic              w_is_space;
  logic              w_acc_dir;
  logic              w_acc_space;
  logic              w_step;
  logic signed [10:0] w_x_sum;
  logic signed [10:0] w_y_sum;

  assign w_new_key    = (keycode != r_key_prev) && (keycode != 8'h00);
  assign w_is_dir_key = (keycode == KEY_W) || (keycode == KEY_A) ||
                        (keycode == KEY_S) || (keycode == KEY_D);
  assign w_is_space   = (keycode == KEY_SPACE);
  assign w_acc_dir    = w_new_key && w_is_dir_key;
  assign w_acc_space  = w_new_key && w_is_space;

  // Recentre beats a same-cycle frame step.
  assign w_step  = (r_state == S_RUN) && frame_tick && !w_acc_space;
  assign w_x_sum = $signed({1'b0, r_ball_x}) + $signed({{6{r_vx[4]}}, r_vx});
  assign w_y_sum = $signed({1'b0, r_ball_y}) + $signed({{6{r_vy[4]}}, r_vy});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ball_x_nxt    = r_ball_x;
    w_ball_y_nxt    = r_ball_y;
    w_vx_nxt        = r_vx;
    w_vy_nxt        = r_vy;
    w_dir_nxt       = r_dir;
    w_key_event_nxt = w_acc_dir || w_acc_space;

    if (w_step) begin
      if (w_x_sum > X_HI) begin
        w_vx_nxt     = V_NEG;
        w_ball_x_nxt = r_ball_x - STEP_U;
        w_dir_nxt    = DIR_LEFT;
      end else if (w_x_sum < X_LO) begin
        w_vx_nxt     = V_POS;
        w_ball_x_nxt = r_ball_x + STEP_U;
        w_dir_nxt    = DIR_RIGHT;
      end else begin
        w_ball_x_nxt = w_x_sum[9:0];
      end

      if (w_y_sum > Y_HI) begin
        w_vy_nxt     = V_NEG;
        w_ball_y_nxt = r_ball_y - STEP_U;
        w_dir_nxt    = DIR_UP;
      end else if (w_y_sum < Y_LO) begin
        w_vy_nxt     = V_POS;
        w_ball_y_nxt = r_ball_y + STEP_U;
        w_dir_nxt    = DIR_DOWN;
      end else begin
        w_ball_y_nxt = w_y_sum[9:0];
      end
    end

    // A key accepted on a tick edge only sets the velocity for the next frame.
    if (w_acc_dir) begin
      w_state_nxt = S_RUN;
      case (keycode)
        KEY_W: begin
          w_vx_nxt  = V_ZERO;
          w_vy_nxt  = V_NEG;
          w_dir_nxt = DIR_UP;
        end
        KEY_A: begin
          w_vx_nxt  = V_NEG;
          w_vy_nxt  = V_ZERO;
          w_dir_nxt = DIR_LEFT;
        end
        KEY_S: begin
          w_vx_nxt  = V_ZERO;
          w_vy_nxt  = V_POS;
          w_dir_nxt = DIR_DOWN;
        end
        default: begin
          w_vx_nxt  = V_POS;
          w_vy_nxt  = V_ZERO;
          w_dir_nxt = DIR_RIGHT;
        end
      endcase
    end

    if (w_acc_space) begin
      w_state_nxt  = S_IDLE;
      w_ball_x_nxt = X_C;
      w_ball_y_nxt = Y_C;
      w_vx_nxt     = V_ZERO;
      w_vy_nxt     = V_ZERO;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_prev  <= 8'h00;
      r_ball_x    <= X_C;
      r_ball_y    <= Y_C;
      r_vx        <= V_ZERO;
      r_vy        <= V_ZERO;
      r_dir       <= DIR_UP;
      r_key_event <= 1'b0;
    end else begin
      r_key_prev  <= keycode;
      r_ball_x    <= w_ball_x_nxt;
      r_ball_y    <= w_ball_y_nxt;
      r_vx        <= w_vx_nxt;
      r_vy        <= w_vy_nxt;
      r_dir       <= w_dir_nxt;
      r_key_event <= w_key_event_nxt;
    end
  end

  assign ball_x    = r_ball_x;
  assign ball_y    = r_ball_y;
  assign ball_size = 10'(SIZE);
  assign dir       = r_dir;
  assign moving    = (r_state == S_RUN);
  assign key_event = r_key_event;

endmodule

// File: tb/tb_keycode_ball_ctrl.sv
// Bench for keycode_ball_ctrl: directed vector table, wall/corner sequences,
// and random keycode/tick traffic against an integer reference model.
module tb_keycode_ball_ctrl;

  localparam int XC = 320;
  localparam int YC = 240;
  localparam int ST = 1;
  localparam int XLO = 4;
  localparam int XHI = 635;
  localparam int YLO = 4;
  localparam int YHI = 475;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] ball_size;
  logic [1:0] dir;
  logic       moving;
  logic       key_event;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_x, m_y, m_vx, m_vy, m_dir, m_run, m_ev, m_prev;

  keycode_ball_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_size  (ball_size),
    .dir        (dir),
    .moving     (moving),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = XC; m_y = YC; m_vx = 0; m_vy = 0;
    m_dir = 0; m_run = 0; m_ev = 0; m_prev = 0;
  endtask

  // One clock of the behavioural rules, applied to integer state.
  task automatic model_step(input int kc, input bit tk);
    bit known, accepted, is_space;
    int t;
    known    = (kc == 'h1A) || (kc == 'h04) || (kc == 'h16) || (kc == 'h07) || (kc == 'h2C);
    accepted = known && (kc != m_prev) && (kc != 0);
    is_space = accepted && (kc == 'h2C);
    if (m_run == 1 && tk && !is_space) begin
      t = m_x + m_vx;
      if (t > XHI) begin m_x = m_x - ST; m_vx = -ST; m_dir = 1; end
      else if (t < XLO) begin m_x = m_x + ST; m_vx = ST; m_dir = 3; end
      else m_x = t;
      t = m_y + m_vy;
      if (t > YHI) begin m_y = m_y - ST; m_vy = -ST; m_dir = 0; end
      else if (t < YLO) begin m_y = m_y + ST; m_vy = ST; m_dir = 2; end
      else m_y = t;
    end
    if (accepted) begin
      case (kc)
        'h1A: begin m_vx = 0;   m_vy = -ST; m_dir = 0; m_run = 1; end
        'h04: begin m_vx = -ST; m_vy = 0;   m_dir = 1; m_run = 1; end
        'h16: begin m_vx = 0;   m_vy = ST;  m_dir = 2; m_run = 1; end
        'h07: begin m_vx = ST;  m_vy = 0;   m_dir = 3; m_run = 1; end
        default: begin m_x = XC; m_y = YC; m_vx = 0; m_vy = 0; m_run = 0; end
      endcase
    end
    m_ev   = accepted ? 1 : 0;
    m_prev = kc;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"},   16'(ball_x),    16'(m_x));
    check({tag, ".y"},   16'(ball_y),    16'(m_y));
    check({tag, ".dir"}, 16'(dir),       16'(m_dir));
    check({tag, ".mv"},  16'(moving),    16'(m_run));
    check({tag, ".ev"},  16'(key_event), 16'(m_ev));
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
  task automatic cycle(input logic [7:0] kc, input logic tk);
    keycode = kc;
    frame_tick = tk;
    @(posedge clk);
    model_step(int'(kc), tk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    keycode = 8'h00;
    frame_tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] kc;
    logic       tk;
    int         x;
    int         y;
    int         d;
    int         mv;
    int         ev;
  } vec_t;

  vec_t vt[18];
  logic [7:0] codes[8];

  initial begin
    vt[0]  = '{8'h07, 1'b0, 320, 240, 3, 1, 1};
    vt[1]  = '{8'h07, 1'b1, 321, 240, 3, 1, 0};
    vt[2]  = '{8'h07, 1'b0, 321, 240, 3, 1, 0};
    vt[3]  = '{8'h07, 1'b1, 322, 240, 3, 1, 0};
    vt[4]  = '{8'h07, 1'b1, 323, 240, 3, 1, 0};
    vt[5]  = '{8'h00, 1'b1, 324, 240, 3, 1, 0};
    vt[6]  = '{8'h55, 1'b0, 324, 240, 3, 1, 0};
    vt[7]  = '{8'h1A, 1'b1, 325, 240, 0, 1, 1};
    vt[8]  = '{8'h1A, 1'b1, 325, 239, 0, 1, 0};
    vt[9]  = '{8'h04, 1'b0, 325, 239, 1, 1, 1};
    vt[10] = '{8'h04, 1'b1, 324, 239, 1, 1, 0};
    vt[11] = '{8'h2C, 1'b1, 320, 240, 1, 0, 1};
    vt[12] = '{8'h2C, 1'b1, 320, 240, 1, 0, 0};
    vt[13] = '{8'h00, 1'b1, 320, 240, 1, 0, 0};
    vt[14] = '{8'h2C, 1'b0, 320, 240, 1, 0, 1};
    vt[15] = '{8'h16, 1'b1, 320, 240, 2, 1, 1};
    vt[16] = '{8'h16, 1'b1, 320, 241, 2, 1, 0};
    vt[17] = '{8'h55, 1'b1, 320, 242, 2, 1, 0};

    @(negedge clk);
    do_reset();
    check("rst.x", 16'(ball_x), 16'd320);
    check("rst.y", 16'(ball_y), 16'd240);
    check("rst.dir", 16'(dir), 16'd0);
    check("rst.mv", 16'(moving), 16'd0);
    check("rst.ev", 16'(key_event), 16'd0);
    check("rst.size", 16'(ball_size), 16'd4);

    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].kc, vt[i].tk);
      check($sformatf("vec%0d.x", i),   16'(ball_x),    16'(vt[i].x));
      check($sformatf("vec%0d.y", i),   16'(ball_y),    16'(vt[i].y));
      check($sformatf("vec%0d.dir", i), 16'(dir),       16'(vt[i].d));
      check($sformatf("vec%0d.mv", i),  16'(moving),    16'(vt[i].mv));
      check($sformatf("vec%0d.ev", i),  16'(key_event), 16'(vt[i].ev));
    end

    // Direction key on the same edge as a tick while moving right from x=330.
    do_reset();
    cycle(8'h07, 1'b0);
    for (int i = 0; i < 20 && ball_x != 10'd330; i++) cycle(8'h07, 1'b1);
    check("turn.start_x", 16'(ball_x), 16'd330);
    cycle(8'h1A, 1'b1);
    check("turn.x1", 16'(ball_x), 16'd331);
    check("turn.y1", 16'(ball_y), 16'd240);
    check("turn.dir", 16'(dir), 16'd0);
    cycle(8'h1A, 1'b1);
    check("turn.x2", 16'(ball_x), 16'd331);
    check("turn.y2", 16'(ball_y), 16'd239);

    // Right wall bounce, then top wall bounce.
    do_reset();
    cycle(8'h07, 1'b0);
    for (int i = 0; i < 400 && ball_x != 10'd634; i++) cycle(8'h07, 1'b1);
    check("rwall.start", 16'(ball_x), 16'd634);
    cycle(8'h07, 1'b1);
    check("rwall.x635", 16'(ball_x), 16'd635);
    check("rwall.dir_r", 16'(dir), 16'd3);
    cycle(8'h07, 1'b1);
    check("rwall.x634", 16'(ball_x), 16'd634);
    check("rwall.dir_l", 16'(dir), 16'd1);
    cycle(8'h07, 1'b1);
    check("rwall.x633", 16'(ball_x), 16'd633);
    check_model("rwall");
    cycle(8'h1A, 1'b0);
    for (int i = 0; i < 300 && ball_y != 10'd4; i++) cycle(8'h1A, 1'b1);
    check("twall.start", 16'(ball_y), 16'd4);
    cycle(8'h1A, 1'b1);
    check("twall.y5", 16'(ball_y), 16'd5);
    check("twall.dir", 16'(dir), 16'd2);
    check("twall.x", 16'(ball_x), 16'd633);
    cycle(8'h00, 1'b1);
    check("twall.y6", 16'(ball_y), 16'd6);
    check_model("twall");

    // Unrecognised key while idle, then asynchronous reset mid-run.
    do_reset();
    cycle(8'h55, 1'b0);
    check("bad.ev", 16'(key_event), 16'd0);
    check("bad.mv", 16'(moving), 16'd0);
    cycle(8'h55, 1'b1);
    check("bad.x", 16'(ball_x), 16'd320);
    check("bad.y", 16'(ball_y), 16'd240);
    cycle(8'h04, 1'b0);
    cycle(8'h04, 1'b1);
    cycle(8'h04, 1'b1);
    check("arst.pre_x", 16'(ball_x), 16'd318);
    #2 reset_n = 1'b0;
    #1;
    check("arst.x", 16'(ball_x), 16'd320);
    check("arst.y", 16'(ball_y), 16'd240);
    check("arst.dir", 16'(dir), 16'd0);
    check("arst.mv", 16'(moving), 16'd0);
    check("arst.ev", 16'(key_event), 16'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic against the reference model.
    codes[0] = 8'h00; codes[1] = 8'h1A; codes[2] = 8'h04; codes[3] = 8'h16;
    codes[4] = 8'h07; codes[5] = 8'h2C; codes[6] = 8'h55; codes[7] = 8'h00;
    begin
      logic [7:0] kc;
      logic       tk;
      kc = 8'h07;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) begin
          int idx;
          idx = int'($urandom_range(0, 7));
          kc = (idx == 7) ? 8'($urandom_range(0, 255)) : codes[idx];
        end
        tk = ($urandom_range(0, 2) == 0);
        cycle(kc, tk);
        check_model($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
